// File: rtl/seg_scan.sv
// Four-digit seven-segment scan driver: steps a digit index at a programmable rate,
// shows a per-frame snapshot of the inputs and blanks the start of every digit slot.
module seg_scan #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data,
    input  logic [3:0]  en,
    input  logic [3:0]  dp,
    output logic [1:0]  sel,
    output logic        digit_on,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [15:0]   sh_data;
    logic [3:0]    sh_en;
    logic [3:0]    sh_dp;

    logic          wrap_c;
    logic          lit_c;
    logic [3:0]    nib_c;
    logic [6:0]    hex_c;

    assign wrap_c = (cnt == CW'(DIV - 1));

    // Prescaler, digit index and end-of-frame snapshot of the display inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            sel        <= 2'd0;
            sh_data    <= 16'h0000;
            sh_en      <= 4'h0;
            sh_dp      <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (wrap_c) begin
                cnt <= '0;
                sel <= sel + 2'd1;
                if (sel == 2'd3) begin
                    sh_data    <= data;
                    sh_en      <= en;
                    sh_dp      <= dp;
                    frame_done <= 1'b1;
                end
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // With no blanking window the slot is lit throughout; avoids a constant compare.
    generate
        if (BLANK == 0) begin : g_noblank
            assign lit_c = 1'b1;
        end else begin : g_blank
            assign lit_c = (cnt >= CW'(BLANK));
        end
    endgenerate

    assign nib_c = sh_data[{sel, 2'b00} +: 4];

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        hex_c = 7'h7F;
        case (nib_c)
            4'h0: hex_c = 7'h40;
            4'h1: hex_c = 7'h79;
            4'h2: hex_c = 7'h24;
            4'h3: hex_c = 7'h30;
            4'h4: hex_c = 7'h19;
            4'h5: hex_c = 7'h12;
            4'h6: hex_c = 7'h02;
            4'h7: hex_c = 7'h78;
            4'h8: hex_c = 7'h00;
            4'h9: hex_c = 7'h10;
            4'hA: hex_c = 7'h08;
            4'hB: hex_c = 7'h03;
            4'hC: hex_c = 7'h46;
            4'hD: hex_c = 7'h21;
            4'hE: hex_c = 7'h06;
            4'hF: hex_c = 7'h0E;
            default: hex_c = 7'h7F;
        endcase
    end

    assign digit_on = sh_en[sel] & lit_c;

    always_comb begin
        seg  = 7'h7F;
        dp_n = 1'b1;
        if (digit_on) begin
            seg  = hex_c;
            dp_n = ~sh_dp[sel];
        end
    end

endmodule
